a25_axil_ram: RTL and testbench

- On-chip AXI-Lite slave SRAM. It sits directly downstream of the A25 AXI-Lite master port.
- It terminates the master's AW/W/B/AR/R channels and stores full-width data words, with byte-strobe writes.
- Default size is 4096 x 128-bit (64 KB). It gives the A25 a boot/scratch memory without an external interconnect.

---
 rtl/a25_axil_pkg.sv | 10 +
 rtl/a25_axil_ram_mem.sv | 24 ++
 rtl/a25_axil_ram.sv | 117 +++++++++++
 tb/tb_a25_axil_ram.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/a25_axil_pkg.sv
// a25_axil_pkg: response codes, FSM state types and address helpers for the AXI-Lite RAM
package a25_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_DATA} r_state_t;
  function automatic int strb_lsb(input int sw);
    return $clog2(sw);
  endfunction
endpackage

// File: rtl/a25_axil_ram_mem.sv
// a25_axil_ram_mem: single-port synchronous RAM with per-byte write enable; dout only updates on reads
module a25_axil_ram_mem
  import a25_axil_pkg::*;
#(
  parameter int DW = 128,
  parameter int SW = DW / 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [SW-1:0] we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < SW; i++)
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      if (!(|we)) dout <= mem[addr];
    end
  end
endmodule

// File: rtl/a25_axil_ram.sv
// a25_axil_ram: AXI-Lite slave SRAM with independent write/read FSMs sharing one RAM port
module a25_axil_ram
  import a25_axil_pkg::*;
#(
  parameter int AXIL_AW = 32,
  parameter int AXIL_DW = 128,
  parameter int AXIL_SW = AXIL_DW / 8,
  parameter int MEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AXIL_AW-1:0] s_axil_awaddr,
  input  logic [2:0]         s_axil_awprot,
  input  logic               s_axil_awvalid,
  output logic               s_axil_awready,
  input  logic [AXIL_DW-1:0] s_axil_wdata,
  input  logic [AXIL_SW-1:0] s_axil_wstrb,
  input  logic               s_axil_wvalid,
  output logic               s_axil_wready,
  output logic [1:0]         s_axil_bresp,
  output logic               s_axil_bvalid,
  input  logic               s_axil_bready,
  input  logic [AXIL_AW-1:0] s_axil_araddr,
  input  logic [2:0]         s_axil_arprot,
  input  logic               s_axil_arvalid,
  output logic               s_axil_arready,
  output logic [AXIL_DW-1:0] s_axil_rdata,
  output logic [1:0]         s_axil_rresp,
  output logic               s_axil_rvalid,
  input  logic               s_axil_rready
);
  localparam int OFF = strb_lsb(AXIL_SW);
  localparam int HW  = AXIL_AW - OFF;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_held, w_held, prio_w;
  logic [HW-1:0] aw_q, ar_q;
  logic [AXIL_DW-1:0] wdata_q, dout;
  logic [AXIL_SW-1:0] wstrb_q, mem_we;
  logic aw_go, w_go, ar_go, aw_have, w_have, w_oor, r_oor;
  logic w_req, r_req, w_gnt, r_gnt, unused_bits;
  assign aw_go   = s_axil_awready & s_axil_awvalid;
  assign w_go    = s_axil_wready & s_axil_wvalid;
  assign ar_go   = s_axil_arready & s_axil_arvalid;
  assign aw_have = aw_held | aw_go;
  assign w_have  = w_held | w_go;
  assign w_oor   = |(aw_q >> MEM_AW);
  assign r_oor   = |(ar_q >> MEM_AW);
  assign w_req   = w_state == W_EXEC;
  assign r_req   = r_state == R_EXEC;
  // prio_w=0 favours the read side on a same-cycle collision
  assign w_gnt   = w_req & (!r_req | prio_w);
  assign r_gnt   = r_req & (!w_req | !prio_w);
  assign mem_we  = (w_gnt && !w_oor) ? wstrb_q : '0;
  assign s_axil_bvalid = w_state == W_RESP;
  assign s_axil_rvalid = r_state == R_DATA;
  assign s_axil_rresp  = (s_axil_rvalid && r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign s_axil_rdata  = (s_axil_rvalid && !r_oor) ? dout : '0;
  assign unused_bits   = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[OFF-1:0], s_axil_araddr[OFF-1:0]};
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_have && w_have) w_next = W_EXEC;
      W_EXEC:  if (w_gnt) w_next = W_RESP;
      W_RESP:  if (s_axil_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_go) r_next = R_EXEC;
      R_EXEC:  if (r_gnt) r_next = R_DATA;
      R_DATA:  if (s_axil_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_arready <= 1'b0;
      prio_w         <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      w_state        <= w_next;
      r_state        <= r_next;
      s_axil_awready <= (w_state == W_IDLE) ? !aw_have : (w_state == W_RESP && s_axil_bready);
      s_axil_wready  <= (w_state == W_IDLE) ? !w_have : (w_state == W_RESP && s_axil_bready);
      aw_held        <= (w_state == W_IDLE) && aw_have && !w_have;
      w_held         <= (w_state == W_IDLE) && w_have && !aw_have;
      s_axil_arready <= (r_state == R_IDLE) ? !ar_go : (r_state == R_DATA && s_axil_rready);
      if (w_req && r_req) prio_w <= !prio_w;
      if (w_gnt) s_axil_bresp <= w_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end
  always_ff @(posedge clk) begin
    if (aw_go) aw_q <= s_axil_awaddr[AXIL_AW-1:OFF];
    if (ar_go) ar_q <= s_axil_araddr[AXIL_AW-1:OFF];
    if (w_go) begin
      wdata_q <= s_axil_wdata;
      wstrb_q <= s_axil_wstrb;
    end
  end
  a25_axil_ram_mem #(.DW(AXIL_DW), .SW(AXIL_SW), .AW(MEM_AW)) u_mem (
    .clk  (clk),
    .en   (r_gnt | (|mem_we)),
    .we   (mem_we),
    .addr (w_gnt ? aw_q[MEM_AW-1:0] : ar_q[MEM_AW-1:0]),
    .din  (wdata_q),
    .dout (dout)
  );
endmodule

// File: tb/tb_a25_axil_ram.sv
// tb_a25_axil_ram: table-driven and randomized checks of the AXI-Lite RAM against a word-array model
module tb_a25_axil_ram;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] ER = 2'b10;
  localparam logic [127:0] D0 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] D4 = 128'h55AA55AA_33CC33CC_0FF00FF0_11223344;
  localparam logic [127:0] ONES = {128{1'b1}};
  logic clk = 0, rst_n = 0;
  logic [31:0] s_axil_awaddr = 0, s_axil_araddr = 0;
  logic [2:0] s_axil_awprot = 0, s_axil_arprot = 0;
  logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_arvalid = 0, s_axil_bready = 0, s_axil_rready = 0;
  logic [127:0] s_axil_wdata = 0;
  logic [15:0] s_axil_wstrb = 0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [127:0] s_axil_rdata;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  a25_axil_ram dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );
  typedef struct {
    bit dw, dr;
    logic [31:0] wa;
    logic [127:0] wd;
    logic [15:0] ws;
    logic [31:0] ra;
    int lw, lr;
    logic [1:0] br, rr;
    logic [127:0] rd;
  } vec_t;
  vec_t tbl[14];
  logic [127:0] m_mem [16];
  bit prio_write;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // Launches an optional write and an optional read in the same cycle and records latency from handshake
  task automatic txn(input bit dw, input bit dr, input logic [31:0] wa, input logic [127:0] wd,
                     input logic [15:0] ws, input logic [31:0] ra, output int lw, output int lr,
                     output logic [1:0] br, output logic [1:0] rr, output logic [127:0] rd);
    int hw, hr;
    bit wdone, rdone, ahs, whs, rhs;
    lw = -1; lr = -1; br = 2'b11; rr = 2'b11; rd = '0; hw = 0; hr = 0;
    wdone = !dw; rdone = !dr;
    s_axil_awaddr = wa; s_axil_wdata = wd; s_axil_wstrb = ws; s_axil_araddr = ra;
    s_axil_awvalid = dw; s_axil_wvalid = dw; s_axil_arvalid = dr;
    s_axil_bready = 1; s_axil_rready = 1;
    for (int k = 0; k < 40 && !(wdone && rdone); k++) begin
      ahs = s_axil_awvalid && s_axil_awready;
      whs = s_axil_wvalid && s_axil_wready;
      rhs = s_axil_arvalid && s_axil_arready;
      if (!wdone && s_axil_bvalid) begin wdone = 1; br = s_axil_bresp; lw = k - hw; end
      if (!rdone && s_axil_rvalid) begin rdone = 1; rr = s_axil_rresp; rd = s_axil_rdata; lr = k - hr; end
      if (ahs || whs) hw = k;
      if (rhs) hr = k;
      tick();
      if (ahs) s_axil_awvalid = 0;
      if (whs) s_axil_wvalid = 0;
      if (rhs) s_axil_arvalid = 0;
    end
    if (!(wdone && rdone)) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: got wdone=%0d rdone=%0d want both 1", wdone, rdone);
      s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit dw, dr, wo, ro;
    int wi, ri, lw, lr, elw, elr;
    logic [31:0] wa, ra;
    logic [127:0] wd, rd, old_v, exp_rd;
    logic [15:0] ws;
    logic [1:0] br, rr;
    tbl[0]  = '{1, 0, 32'h10, D1, 16'hFFFF, 32'h0, 2, 0, OK, OK, 128'h0};
    tbl[1]  = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h10, 0, 2, OK, OK, D1};
    tbl[2]  = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h1C, 0, 2, OK, OK, D1};
    tbl[3]  = '{1, 0, 32'h20, 128'h0, 16'hFFFF, 32'h0, 2, 0, OK, OK, 128'h0};
    tbl[4]  = '{1, 0, 32'h20, ONES, 16'h0001, 32'h0, 2, 0, OK, OK, 128'h0};
    tbl[5]  = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h20, 0, 2, OK, OK, 128'hFF};
    tbl[6]  = '{1, 0, 32'h0, D0, 16'hFFFF, 32'h0, 2, 0, OK, OK, 128'h0};
    tbl[7]  = '{1, 0, 32'h10000, ONES, 16'hFFFF, 32'h0, 2, 0, ER, OK, 128'h0};
    tbl[8]  = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h10000, 0, 2, OK, ER, 128'h0};
    tbl[9]  = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h0, 0, 2, OK, OK, D0};
    tbl[10] = '{1, 1, 32'h10, D2, 16'hFFFF, 32'h10, 3, 2, OK, OK, D1};
    tbl[11] = '{1, 1, 32'h10, D3, 16'hFFFF, 32'h10, 2, 3, OK, OK, D3};
    tbl[12] = '{1, 0, 32'h10, ONES, 16'h0000, 32'h0, 2, 0, OK, OK, 128'h0};
    tbl[13] = '{0, 1, 32'h0, 128'h0, 16'h0, 32'h10, 0, 2, OK, OK, D3};
    repeat (3) tick();
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_bvalid", s_axil_bvalid, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_bresp", s_axil_bresp, 0);
    chk("rst_rresp", s_axil_rresp, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("rel_awready_low", s_axil_awready, 0);
    tick();
    chk("rel_awready", s_axil_awready, 1);
    chk("rel_wready", s_axil_wready, 1);
    chk("rel_arready", s_axil_arready, 1);
    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].dw, tbl[i].dr, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].ra, lw, lr, br, rr, rd);
      if (tbl[i].dw) begin
        chk($sformatf("tbl%0d_blat", i), lw, tbl[i].lw);
        chk($sformatf("tbl%0d_bresp", i), br, tbl[i].br);
      end
      if (tbl[i].dr) begin
        chk($sformatf("tbl%0d_rlat", i), lr, tbl[i].lr);
        chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].rr);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      end
    end
    s_axil_bready = 0;
    s_axil_awaddr = 32'h30; s_axil_wdata = D4; s_axil_wstrb = 16'hFFFF;
    s_axil_wvalid = 1;
    chk("ord_wready0", s_axil_wready, 1);
    tick();
    s_axil_wvalid = 0;
    for (int c = 0; c < 2; c++) begin
      chk("ord_wready_held", s_axil_wready, 0);
      chk("ord_awready_open", s_axil_awready, 1);
      chk("ord_bvalid_early", s_axil_bvalid, 0);
      tick();
    end
    s_axil_awvalid = 1;
    chk("ord_awready", s_axil_awready, 1);
    tick();
    s_axil_awvalid = 0;
    chk("ord_bvalid_exec", s_axil_bvalid, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("ord_bvalid_hold", s_axil_bvalid, 1);
      chk("ord_bresp_hold", s_axil_bresp, OK);
      chk("ord_awready_busy", s_axil_awready, 0);
      chk("ord_wready_busy", s_axil_wready, 0);
      tick();
    end
    s_axil_bready = 1;
    tick();
    chk("ord_bvalid_done", s_axil_bvalid, 0);
    chk("ord_awready_back", s_axil_awready, 1);
    chk("ord_wready_back", s_axil_wready, 1);
    txn(0, 1, 32'h0, 128'h0, 16'h0, 32'h30, lw, lr, br, rr, rd);
    chk("ord_rdata", rd, D4);
    s_axil_rready = 0; s_axil_araddr = 32'h10; s_axil_arvalid = 1;
    tick();
    s_axil_arvalid = 0;
    tick();
    tick();
    chk("rst_mid_rvalid", s_axil_rvalid, 1);
    chk("rst_mid_rdata", s_axil_rdata, D3);
    tick();
    chk("rst_mid_rdata_hold", s_axil_rdata, D3);
    #2 rst_n = 0;
    #1 chk("rst_mid_async_rvalid", s_axil_rvalid, 0);
    chk("rst_mid_async_arready", s_axil_arready, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1 chk("rst_mid_arready_low", s_axil_arready, 0);
    tick();
    chk("rst_mid_arready", s_axil_arready, 1);
    s_axil_rready = 1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_mid_no_beat", s_axil_rvalid, 0);
      tick();
    end
    prio_write = 0;
    for (int i = 0; i < 16; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      txn(1, 0, 32'(i * 16), wd, 16'hFFFF, 32'h0, lw, lr, br, rr, rd);
      m_mem[i] = wd;
      chk("init_bresp", br, OK);
    end
    for (int n = 0; n < 150; n++) begin
      dw = 1'($urandom_range(0, 1));
      dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      wi = $urandom_range(0, 15);
      ri = $urandom_range(0, 15);
      wo = ($urandom_range(0, 7) == 0);
      ro = ($urandom_range(0, 7) == 0);
      wa = {wo ? 16'($urandom_range(1, 65535)) : 16'h0, 8'h0, wi[3:0], 4'($urandom)};
      ra = {ro ? 16'($urandom_range(1, 65535)) : 16'h0, 8'h0, ri[3:0], 4'($urandom)};
      wd = {$urandom, $urandom, $urandom, $urandom};
      ws = 16'($urandom);
      old_v = m_mem[ri];
      if (dw && !wo)
        for (int b = 0; b < 16; b++)
          if (ws[b]) m_mem[wi][8*b +: 8] = wd[8*b +: 8];
      exp_rd = ro ? 128'h0 : ((dw && dr && !prio_write) ? old_v : m_mem[ri]);
      elw = (dw && dr && !prio_write) ? 3 : 2;
      elr = (dw && dr && prio_write) ? 3 : 2;
      if (dw && dr) prio_write = !prio_write;
      txn(dw, dr, wa, wd, ws, ra, lw, lr, br, rr, rd);
      if (dw) begin
        chk($sformatf("rnd%0d_blat", n), lw, elw);
        chk($sformatf("rnd%0d_bresp", n), br, wo ? ER : OK);
      end
      if (dr) begin
        chk($sformatf("rnd%0d_rlat", n), lr, elr);
        chk($sformatf("rnd%0d_rresp", n), rr, ro ? ER : OK);
        chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
